snp_req_initiator: RTL and testbench

SNP_REQ_INITIATOR -- requirements
Module: snp_req_initiator

---
 rtl/snp_req_initiator.sv | 151 +++++++++++++++
 tb/tb_snp_req_initiator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/snp_req_initiator.sv
`default_nettype none
// ============================================================================
// Module   : snp_req_initiator
// Purpose  : Broadcasts a snoop for a local miss, then collects one response per
//            peer to produce the requester's next MESI state.
// Option   : SNP_TIMEOUT_EN adds a COLLECT-phase timeout (done_err=1).
// Revision : 1.0 - initial release
// ============================================================================
module snp_req_initiator #(
   parameter int NUM_PEERS   = 3,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [1:0]             req_op,
   input  logic [ADDR_W-1:0]      req_addr,
   output logic                   snp_valid,
   input  logic                   snp_ready,
   output logic [1:0]             snp_op,
   output logic [ADDR_W-1:0]      snp_addr,
   input  logic [NUM_PEERS-1:0]   rsp_valid,
   input  logic [2*NUM_PEERS-1:0] rsp_rsp,
   output logic                   done_valid,
   output logic [2:0]             done_nxtSt,
   output logic                   done_err,
   output logic                   busy
);

   localparam logic [1:0] SUREQ_RD   = 2'd0;
   localparam logic [1:0] SUREQ_RFO  = 2'd1;
   localparam logic [1:0] SUREQ_INV  = 2'd2;
   localparam logic [1:0] SDRSP_OKAY = 2'd0;
   localparam logic [2:0] MESI_I     = 3'd0;
   localparam logic [2:0] MESI_S     = 3'd1;
   localparam logic [2:0] MESI_E     = 3'd2;
   localparam logic [2:0] MESI_M     = 3'd3;

   typedef enum logic [1:0] {IDLE, ISSUE, COLLECT, DONE} state_t;

   state_t                state;
   logic [1:0]            op_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [NUM_PEERS-1:0]  pending;
   logic [NUM_PEERS-1:0]  rsp_hit;
   logic [NUM_PEERS-1:0]  rsp_okay;
   logic [NUM_PEERS-1:0]  pending_nxt;
   logic                  sharer;
   logic                  sharer_nxt;
   logic                  tmo_hit;

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   for (genvar i = 0; i < NUM_PEERS; i++) begin : g_peer
      assign rsp_hit[i]  = rsp_valid[i] & pending[i];
      assign rsp_okay[i] = rsp_hit[i] & (rsp_rsp[2*i +: 2] == SDRSP_OKAY);
   end

   assign pending_nxt = pending & ~rsp_hit;
   assign sharer_nxt  = sharer | (|rsp_okay);

   function automatic logic [2:0] grant_state(input logic [1:0] op, input logic shr);
      case (op)
         SUREQ_RD:  return shr ? MESI_S : MESI_E;
         SUREQ_RFO: return MESI_M;
         SUREQ_INV: return MESI_M;
         default:   return MESI_M;
      endcase
   endfunction

`ifdef SNP_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] tmo_cnt;

   // Cleared while ISSUE is waiting, so it is zero on the first COLLECT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (state == ISSUE)
         tmo_cnt <= '0;
      else if (state == COLLECT && (|pending))
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         op_q       <= SUREQ_RD;
         addr_q     <= '0;
         pending    <= '0;
         sharer     <= 1'b0;
         done_valid <= 1'b0;
         done_nxtSt <= MESI_I;
         done_err   <= 1'b0;
      end else begin
         done_valid <= 1'b0;
         done_nxtSt <= MESI_I;
         done_err   <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  addr_q <= req_addr;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               if (snp_ready) begin
                  pending <= '1;
                  sharer  <= 1'b0;
                  state   <= COLLECT;
               end
            end
            COLLECT: begin
               pending <= pending_nxt;
               sharer  <= sharer_nxt;
               // A final response in the timeout cycle wins over the timeout.
               if (pending_nxt == '0) begin
                  state      <= DONE;
                  done_valid <= 1'b1;
                  done_nxtSt <= grant_state(op_q, sharer_nxt);
               end else if (tmo_hit) begin
                  state      <= DONE;
                  pending    <= '0;
                  done_valid <= 1'b1;
                  done_err   <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign snp_valid = (state == ISSUE);
   assign busy      = (state != IDLE);
   assign snp_op    = op_q;
   assign snp_addr  = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_snp_req_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_snp_req_initiator
// Purpose  : Directed and randomized checks of snp_req_initiator against a
//            transaction-level reference model (SNP_TIMEOUT_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
module tb_snp_req_initiator;
   localparam int NP  = 3;
   localparam int AW  = 32;
   localparam int TMO = 64;
   localparam logic [1:0] RD = 2'd0, RFO = 2'd1, INV = 2'd2;
   localparam logic [1:0] OKAY = 2'd0, SINV = 2'd1;
   localparam logic [2:0] ST_I = 3'd0, ST_S = 3'd1, ST_E = 3'd2, ST_M = 3'd3;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req_valid, req_ready;
   logic [1:0]      req_op;
   logic [AW-1:0]   req_addr;
   logic            snp_valid, snp_ready;
   logic [1:0]      snp_op;
   logic [AW-1:0]   snp_addr;
   logic [NP-1:0]   rsp_valid;
   logic [2*NP-1:0] rsp_rsp;
   logic            done_valid, done_err, busy;
   logic [2:0]      done_nxtSt;

   always #5 clk = ~clk;

   snp_req_initiator #(.NUM_PEERS(NP), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
      .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_op(snp_op), .snp_addr(snp_addr),
      .rsp_valid(rsp_valid), .rsp_rsp(rsp_rsp),
      .done_valid(done_valid), .done_nxtSt(done_nxtSt), .done_err(done_err), .busy(busy)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level reference model ----------------
   bit            m_busy, m_bcast, m_fin, m_err, m_shr;
   logic [NP-1:0] m_out;
   logic [1:0]    m_op;
   logic [AW-1:0] m_addr;
   logic [2:0]    m_nxt;
   int            m_wait;

   function automatic logic [2:0] expect_state(input logic [1:0] op, input bit shr);
      if (op == RD) return shr ? ST_S : ST_E;
      return ST_M;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_bcast = 0; m_fin = 0; m_err = 0; m_shr = 0;
         m_out = '0; m_nxt = ST_I; m_wait = 0;
      end else if (m_fin) begin
         m_fin = 0; m_busy = 0; m_err = 0; m_nxt = ST_I;
      end else if (!m_busy) begin
         if (req_valid) begin
            m_busy = 1; m_bcast = 1; m_op = req_op; m_addr = req_addr;
         end
      end else if (m_bcast) begin
         if (snp_ready) begin
            m_bcast = 0; m_out = '1; m_shr = 0; m_wait = 0;
         end
      end else begin
         for (int i = 0; i < NP; i++)
            if (rsp_valid[i] && m_out[i]) begin
               m_out[i] = 1'b0;
               if (rsp_rsp[2*i +: 2] == OKAY) m_shr = 1;
            end
         m_wait++;
         if (m_out == '0) begin
            m_fin = 1; m_nxt = expect_state(m_op, m_shr);
         end
`ifdef SNP_TIMEOUT_EN
         else if (m_wait == TMO) begin
            m_fin = 1; m_err = 1; m_nxt = ST_I;
         end
`endif
      end
   end

   always @(negedge clk) begin
      chk("req_ready", req_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("snp_valid", snp_valid, m_bcast);
      chk("done_valid", done_valid, m_fin);
      chk("done_nxtSt", done_nxtSt, m_nxt);
      chk("done_err", done_err, m_err);
      if (m_bcast) begin
         chk("snp_op", snp_op, m_op);
         chk("snp_addr", snp_addr, m_addr);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk); #2;
   endtask

   task automatic idle_inputs();
      req_valid = 0; req_op = RD; req_addr = '0; snp_ready = 0; rsp_valid = '0; rsp_rsp = '0;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (!req_ready && k < 200) begin cyc(); k++; end
      chk("idle_reached", req_ready, 1'b1);
   endtask

   // Request accepted at the next edge, snoop accepted one edge later;
   // returns in the first COLLECT cycle.
   task automatic start(input logic [1:0] op, input logic [AW-1:0] addr);
      req_valid = 1; req_op = op; req_addr = addr; snp_ready = 1;
      cyc();
      req_valid = 0;
      chk("start_snp_valid", snp_valid, 1'b1);
      chk("start_snp_addr", snp_addr, addr);
      cyc();
      snp_ready = 0;
   endtask

   task automatic basic_rd();
      wait_idle();
      start(RD, 32'h40);
      rsp_valid = 3'b111; rsp_rsp = 6'b010101;
      cyc();
      rsp_valid = '0;
      chk("a_done_t3", done_valid, 1'b1);
      chk("a_nxt_excl", done_nxtSt, 3'd2);
      chk("a_err", done_err, 1'b0);
      cyc();
      chk("a_pulse_once", done_valid, 1'b0);
      chk("a_ready_back", req_ready, 1'b1);
   endtask

   initial begin
      rst_n = 0;
      idle_inputs();
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_snp_valid", snp_valid, 1'b0);
      chk("rst_done_valid", done_valid, 1'b0);
      chk("rst_nxt", done_nxtSt, 3'd0);
      chk("rst_err", done_err, 1'b0);
      #11 rst_n = 1;
      cyc();

      basic_rd();

      // RD with separate responses, peer1 holds the line
      wait_idle();
      start(RD, 32'h1234);
      rsp_valid = 3'b001; rsp_rsp = 6'b000001;
      cyc(); chk("b_no_done0", done_valid, 1'b0);
      rsp_valid = 3'b010; rsp_rsp = 6'b000000;
      cyc(); chk("b_no_done1", done_valid, 1'b0);
      rsp_valid = 3'b100; rsp_rsp = 6'b010000;
      cyc(); rsp_valid = '0;
      chk("b_done", done_valid, 1'b1);
      chk("b_nxt_shared", done_nxtSt, 3'd1);

      // RFO with snp_ready stalled five cycles; request inputs wander meanwhile
      wait_idle();
      req_valid = 1; req_op = RFO; req_addr = 32'hDEAD_BEE0; snp_ready = 0;
      cyc();
      req_valid = 0; req_op = INV;
      for (int k = 0; k < 6; k++) begin
         req_addr = $urandom;
         chk("c_snp_valid", snp_valid, 1'b1);
         chk("c_snp_op", snp_op, 2'd1);
         chk("c_snp_addr", snp_addr, 32'hDEAD_BEE0);
         if (k == 5) snp_ready = 1;
         cyc();
      end
      snp_ready = 0;
      chk("c_snp_dropped", snp_valid, 1'b0);
      rsp_valid = 3'b111; rsp_rsp = 6'b000000;
      cyc(); rsp_valid = '0;
      chk("c_done", done_valid, 1'b1);
      chk("c_nxt_mod", done_nxtSt, 3'd3);

      // duplicate peer0 response must not complete the transaction
      wait_idle();
      start(INV, 32'h80);
      rsp_valid = 3'b001; rsp_rsp = 6'b000000;
      cyc(); cyc();
      rsp_valid = '0;
      cyc(); cyc();
      chk("d_no_done", done_valid, 1'b0);
      chk("d_still_busy", busy, 1'b1);
      rsp_valid = 3'b110;
      cyc(); rsp_valid = '0;
      chk("d_done", done_valid, 1'b1);
      chk("d_nxt_mod", done_nxtSt, 3'd3);
      cyc();
      chk("d_single_pulse", done_valid, 1'b0);

      // peer2 never answers
      wait_idle();
      start(RD, 32'h100);
      rsp_valid = 3'b011; rsp_rsp = 6'b010101;
      cyc(); rsp_valid = '0;
`ifdef SNP_TIMEOUT_EN
      begin
         int n = 1;
         while (!done_valid && n < 200) begin cyc(); n++; end
         chk("e_tmo_cycles", n, 64);
         chk("e_tmo_err", done_err, 1'b1);
         chk("e_tmo_nxt", done_nxtSt, 3'd0);
      end
      // last response lands exactly in the timeout cycle
      wait_idle();
      start(RD, 32'h140);
      rsp_valid = 3'b011; rsp_rsp = 6'b010101;
      cyc(); rsp_valid = '0;
      repeat (62) cyc();
      rsp_valid = 3'b100;
      cyc(); rsp_valid = '0;
      chk("e_prio_done", done_valid, 1'b1);
      chk("e_prio_err", done_err, 1'b0);
      chk("e_prio_nxt", done_nxtSt, 3'd2);
      wait_idle();
      start(RFO, 32'h180);
`else
      repeat (100) cyc();
      chk("e_hang_busy", busy, 1'b1);
      chk("e_hang_no_done", done_valid, 1'b0);
`endif

      // reset in the middle of COLLECT
      rst_n = 0;
      #1;
      chk("f_busy", busy, 1'b0);
      chk("f_ready", req_ready, 1'b1);
      chk("f_snp_valid", snp_valid, 1'b0);
      cyc(); cyc();
      chk("f_no_done", done_valid, 1'b0);
      rst_n = 1;
      cyc();
      basic_rd();

      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_op    = 2'($urandom_range(0, 2));
         req_addr  = $urandom;
         snp_ready = ($urandom_range(0, 3) != 0);
         rsp_valid = NP'($urandom);
         for (int i = 0; i < NP; i++) rsp_rsp[2*i +: 2] = 2'($urandom_range(0, 1));
         cyc();
      end
      idle_inputs();
      repeat (10) cyc();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
